// File: rtl/ifu_fetch.sv
// Instruction fetch stage: word-aligned imem reads realigned into RV32IC 16/32-bit
// instructions, with a 3-halfword buffer and redirect handling for in-flight reads.
module ifu_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redir_en_i,
    input  logic [XLEN-1:0] redir_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_data_o,
    output logic [XLEN-1:0] inst_pc_o
);

    typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fa_q, fa_d;
    logic [XLEN-1:0] ip_q, ip_d;
    logic [15:0]     hb_q [3];
    logic [15:0]     hb_d [3];
    logic [1:0]      cnt_q, cnt_d;
    logic [2:0]      cnt_s;
    logic            skip_q, skip_d;
    logic            run_q;
    logic            is32, consume, req_gnt, rsp, outstanding;

    assign is32         = (hb_q[0][1:0] == 2'b11);
    assign inst_valid_o = is32 ? (cnt_q >= 2'd2) : (cnt_q >= 2'd1);
    assign inst_data_o  = !inst_valid_o ? 32'h0 :
                          is32 ? {hb_q[1], hb_q[0]} : {16'h0, hb_q[0]};
    assign inst_pc_o    = ip_q;

    // run_q keeps req_o low while reset is asserted; requests start the cycle after release.
    assign imem_req_o   = run_q && (state_q == StReq) && (cnt_q <= 2'd1);
    assign imem_addr_o  = fa_q;

    assign req_gnt      = imem_req_o && imem_gnt_i;
    assign rsp          = imem_rvalid_i && (state_q == StWait);
    assign consume      = inst_valid_o && inst_ready_i;
    assign outstanding  = ((state_q == StWait) || (state_q == StDrop)) && !imem_rvalid_i;

    always_comb begin
        state_d = state_q;
        fa_d    = fa_q;
        ip_d    = ip_q;
        hb_d    = hb_q;
        skip_d  = skip_q;
        cnt_s   = {1'b0, cnt_q};
        if (redir_en_i) begin
            cnt_s   = 3'd0;
            ip_d    = redir_pc_i & ~XLEN'(1);
            fa_d    = redir_pc_i & ~XLEN'(3);
            skip_d  = redir_pc_i[1];
            state_d = (outstanding || req_gnt) ? StDrop : StReq;
        end else begin
            if (consume) begin
                ip_d = ip_q + (is32 ? XLEN'(4) : XLEN'(2));
                if (is32) begin
                    hb_d  = '{hb_q[2], 16'h0, 16'h0};
                    cnt_s = cnt_s - 3'd2;
                end else begin
                    hb_d  = '{hb_q[1], hb_q[2], 16'h0};
                    cnt_s = cnt_s - 3'd1;
                end
            end
            // Append lands after the shift; a skipped lower halfword is the pre-target half.
            if (rsp) begin
                for (int i = 0; i < 3; i++) begin
                    if (skip_q) begin
                        if (3'(i) == cnt_s) hb_d[i] = imem_rdata_i[31:16];
                    end else begin
                        if (3'(i) == cnt_s) hb_d[i] = imem_rdata_i[15:0];
                        else if (3'(i) == cnt_s + 3'd1) hb_d[i] = imem_rdata_i[31:16];
                    end
                end
                cnt_s  = cnt_s + (skip_q ? 3'd1 : 3'd2);
                skip_d = 1'b0;
            end
            unique case (state_q)
                StReq: begin
                    if (req_gnt) begin
                        fa_d    = fa_q + XLEN'(4);
                        state_d = StWait;
                    end
                end
                StWait:  if (imem_rvalid_i) state_d = StReq;
                StDrop:  if (imem_rvalid_i) state_d = StReq;
                default: state_d = StReq;
            endcase
        end
        cnt_d = cnt_s[1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StReq;
            fa_q    <= RESET_PC & ~XLEN'(3);
            ip_q    <= RESET_PC & ~XLEN'(1);
            cnt_q   <= 2'd0;
            skip_q  <= RESET_PC[1];
            run_q   <= 1'b0;
            for (int i = 0; i < 3; i++) hb_q[i] <= 16'h0;
        end else begin
            state_q <= state_d;
            fa_q    <= fa_d;
            ip_q    <= ip_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            run_q   <= 1'b1;
            for (int i = 0; i < 3; i++) hb_q[i] <= hb_d[i];
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus randomized memory/consumer/redirect
// traffic checked against a program-order instruction model.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redir_en_i;
    logic [31:0] redir_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_data_o;
    logic [31:0] inst_pc_o;

    ifu_fetch #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redir_en_i   (redir_en_i),
        .redir_pc_i   (redir_pc_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_data_o  (inst_data_o),
        .inst_pc_o    (inst_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; int due;} rsp_t;
    typedef struct {logic [31:0] data; logic [31:0] pc;} ins_t;

    rsp_t        memq[$];
    ins_t        expq[$];
    logic [31:0] mem_ovr[logic [31:0]];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_cons = 0;
    logic [31:0] exp_pc;
    int          gnt_pct, rdy_pct, redir_pm, lat_min, lat_max;
    bit          do_redir, redir_prev, addr_chk_pend;
    logic [31:0] redir_tgt, addr_chk_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5BD1_E995;
    endfunction

    function automatic logic [15:0] hw(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_rd({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // Program-order view: the instruction that starts at pc.
    function automatic ins_t model(input logic [31:0] pc);
        ins_t        r;
        logic [15:0] lo;
        lo     = hw(pc);
        r.pc   = pc;
        r.data = (lo[1:0] != 2'b11) ? {16'h0, lo} : {hw(pc + 32'd2), lo};
        return r;
    endfunction

    task automatic tick();
        ins_t        e;
        rsp_t        r;
        logic [31:0] t;
        @(negedge clk);
        cyc++;
        if (redir_prev) chk("redir_valid_low", 32'(inst_valid_o), 32'd0);
        if (inst_valid_o) begin
            e = (expq.size() > 0) ? expq[0] : model(exp_pc);
            chk("inst_data", inst_data_o, e.data);
            chk("inst_pc", inst_pc_o, e.pc);
        end
        if (imem_req_o) begin
            chk("addr_align", 32'(imem_addr_o[1:0]), 32'd0);
            if (addr_chk_pend) begin
                chk("redir_addr", imem_addr_o, addr_chk_exp);
                addr_chk_pend = 1'b0;
            end
        end
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            r             = memq.pop_front();
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_rd(r.addr);
        end
        imem_gnt_i = imem_req_o && ($urandom_range(99) < gnt_pct);
        if (imem_gnt_i) begin
            r.addr = imem_addr_o;
            r.due  = cyc + $urandom_range(lat_min, lat_max);
            memq.push_back(r);
        end
        redir_en_i = 1'b0;
        if (do_redir) begin
            redir_en_i = 1'b1;
            redir_pc_i = redir_tgt;
        end else if ($urandom_range(999) < redir_pm) begin
            t = $urandom & 32'h0000_0FFF;
            if ($urandom_range(7) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            redir_en_i = 1'b1;
            redir_pc_i = t;
        end
        inst_ready_i = ($urandom_range(99) < rdy_pct);
        redir_prev   = redir_en_i;
        if (redir_en_i) begin
            exp_pc = redir_pc_i & ~32'd1;
        end else if (inst_valid_o && inst_ready_i) begin
            n_cons++;
            if (expq.size() > 0) void'(expq.pop_front());
            e      = model(exp_pc);
            exp_pc = exp_pc + ((e.data[1:0] == 2'b11) ? 32'd4 : 32'd2);
        end
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redir_en_i    = 1'b0;
        redir_pc_i    = 32'h0;
        inst_ready_i  = 1'b0;
        memq.delete();
        expq.delete();
        exp_pc        = 32'h100;
        redir_prev    = 1'b0;
        addr_chk_pend = 1'b0;
        do_redir      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'h100);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_data", inst_data_o, 32'h0);
        chk("rst_pc", inst_pc_o, 32'h100);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rel_req", 32'(imem_req_o), 32'd1);
        chk("rel_addr", imem_addr_o, 32'h100);
        chk("rel_valid", 32'(inst_valid_o), 32'd0);
    endtask

    task automatic wait_cons(input int n, input int budget);
        int start, k;
        start = n_cons;
        k     = 0;
        while (n_cons - start < n && k < budget) begin
            tick();
            k++;
        end
        chk("consumed", 32'(n_cons - start), 32'(n));
    endtask

    task automatic knobs(input int g, input int rd, input int lmin, input int lmax, input int rpm);
        gnt_pct  = g;
        rdy_pct  = rd;
        lat_min  = lmin;
        lat_max  = lmax;
        redir_pm = rpm;
    endtask

    function automatic ins_t mk(input logic [31:0] d, input logic [31:0] p);
        ins_t r;
        r.data = d;
        r.pc   = p;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, start;

        // Aligned 32-bit stream.
        mem_ovr.delete();
        mem_ovr[32'h100] = 32'h0000_0013;
        mem_ovr[32'h104] = 32'h0010_0093;
        knobs(100, 100, 1, 1, 0);
        do_reset();
        expq.push_back(mk(32'h0000_0013, 32'h100));
        expq.push_back(mk(32'h0010_0093, 32'h104));
        wait_cons(2, 50);
        chk("t2_drained", 32'(expq.size()), 32'd0);

        // Mixed 16/32 with a straddling 32-bit instruction.
        mem_ovr.delete();
        mem_ovr[32'h100] = 32'h0093_0001;
        mem_ovr[32'h104] = 32'h4505_0010;
        knobs(60, 100, 1, 3, 0);
        do_reset();
        expq.push_back(mk(32'h0000_0001, 32'h100));
        expq.push_back(mk(32'h0010_0093, 32'h102));
        expq.push_back(mk(32'h0000_4505, 32'h106));
        wait_cons(3, 80);
        chk("t3_drained", 32'(expq.size()), 32'd0);

        // Redirect to an odd halfword while a read is outstanding.
        mem_ovr.delete();
        mem_ovr[32'h100] = 32'h0000_0013;
        mem_ovr[32'h200] = 32'h4505_1111;
        knobs(100, 100, 3, 3, 0);
        do_reset();
        k = 0;
        while (memq.size() == 0 && k < 20) begin
            tick();
            k++;
        end
        chk("t4_granted", 32'(memq.size()), 32'd1);
        do_redir  = 1'b1;
        redir_tgt = 32'h202;
        tick();
        do_redir      = 1'b0;
        addr_chk_pend = 1'b1;
        addr_chk_exp  = 32'h200;
        expq.push_back(mk(32'h0000_4505, 32'h202));
        wait_cons(1, 50);
        chk("t4_addr_seen", 32'(addr_chk_pend), 32'd0);

        // Consumer stall: outputs hold, fetch stops, resume in order.
        mem_ovr.delete();
        mem_ovr[32'h100] = 32'h4505_0001;
        mem_ovr[32'h104] = 32'h0010_0093;
        mem_ovr[32'h108] = 32'h0000_0013;
        knobs(100, 0, 1, 1, 0);
        do_reset();
        expq.push_back(mk(32'h0000_0001, 32'h100));
        expq.push_back(mk(32'h0000_4505, 32'h102));
        expq.push_back(mk(32'h0010_0093, 32'h104));
        expq.push_back(mk(32'h0000_0013, 32'h108));
        k = 0;
        while (!inst_valid_o && k < 20) begin
            tick();
            k++;
        end
        for (int i = 0; i < 8; i++) tick();
        chk("stall_valid", 32'(inst_valid_o), 32'd1);
        chk("stall_noreq", 32'(imem_req_o), 32'd0);
        rdy_pct = 100;
        wait_cons(4, 60);
        chk("t5_drained", 32'(expq.size()), 32'd0);

        // Randomized traffic with redirects, including near the top of the address space.
        mem_ovr.delete();
        knobs(70, 70, 1, 4, 15);
        do_reset();
        start = n_cons;
        for (int i = 0; i < 4000; i++) tick();
        chk("random_progress", 32'(n_cons - start > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
